// File: rtl/command_issue_arbiter.sv
// Issues at most one AFU command buffer head line per cycle toward the PSL command port.
// Latency: grant_out is combinational in cycle N; command_out.valid rises for one cycle after edge N.
// Backpressure: PSL command credits gate issue; no grant while credits==0, disabled or fenced.
//
// Ports:
//   clock, rstn                     core clock, synchronous active-low reset
//   enabled_in                      job enabled; grants suppressed while low
//   room_valid_in / room_in         initial PSL command room (loaded once per reset)
//   credit_return_valid_in / _in    credits handed back with each observed response
//   restart_pending_in              fences wed/write/read while restart/flush runs
//   request_in                      {wed, write, read, restart} buffer non-empty levels
//   cmd_*_in                        first-word-fall-through head lines of each buffer
//   grant_out                       one-hot pop pulse, same bit order as request_in
//   command_out                     registered issued line, .valid qualifies
//   credits_out, state_out          available credits and FSM state for debug
//   arb_stats_out                   grant/stall counters, present only with CMD_ARB_STATS_EN

package command_issue_arbiter_pkg;

  typedef struct packed {
    logic        valid;
    logic [12:0] command;
    logic [7:0]  tag;
    logic [11:0] size;
    logic [63:0] address;
  } CommandBufferLine;

  typedef struct packed {
    logic wed_request;
    logic write_request;
    logic read_request;
    logic restart_request;
  } CommandBufferArbiterInterfaceIn;

  typedef enum logic [1:0] {
    ARB_RESET     = 2'd0,
    ARB_WAIT_ROOM = 2'd1,
    ARB_RUN       = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [63:0] restart_grants;
    logic [63:0] wed_grants;
    logic [63:0] write_grants;
    logic [63:0] read_grants;
    logic [63:0] stall_cycles;
  } arb_stats_t;

endpackage

module command_issue_arbiter
  import command_issue_arbiter_pkg::*;
#(
  parameter int CREDIT_BITS = 9,
  parameter int MAX_CREDITS = 64
) (
  input  logic                           clock,
  input  logic                           rstn,
  input  logic                           enabled_in,
  input  logic                           room_valid_in,
  input  logic [CREDIT_BITS-1:0]         room_in,
  input  logic                           credit_return_valid_in,
  input  logic [CREDIT_BITS-1:0]         credit_return_in,
  input  logic                           restart_pending_in,
  input  CommandBufferArbiterInterfaceIn request_in,
  input  CommandBufferLine               cmd_restart_in,
  input  CommandBufferLine               cmd_wed_in,
  input  CommandBufferLine               cmd_write_in,
  input  CommandBufferLine               cmd_read_in,
  output logic [3:0]                     grant_out,
  output CommandBufferLine               command_out,
  output logic [CREDIT_BITS-1:0]         credits_out,
  output logic [1:0]                     state_out
`ifdef CMD_ARB_STATS_EN
  ,
  output arb_stats_t                     arb_stats_out
`endif
);

  localparam logic [CREDIT_BITS-1:0] MAX_C = CREDIT_BITS'(MAX_CREDITS);

  // Grant bit positions follow request_in packing.
  localparam int G_RESTART = 0;
  localparam int G_READ    = 1;
  localparam int G_WRITE   = 2;
  localparam int G_WED     = 3;

  arb_state_t             state_q, state_d;
  logic [CREDIT_BITS-1:0] credits_q, credits_d;
  logic                   rr_write_q, rr_write_d;  // 1: write wins a write/read tie
  CommandBufferLine       command_q, command_d;
  logic [3:0]             grant;
  logic                   can_issue;
  logic                   wed_ok, write_ok, read_ok, restart_ok;
  logic [CREDIT_BITS-1:0] ret_amt;
  logic [CREDIT_BITS:0]   credit_sum;

  function automatic logic [CREDIT_BITS-1:0] clamp_credits(input logic [CREDIT_BITS-1:0] v);
    return (v > MAX_C) ? MAX_C : v;
  endfunction

  assign can_issue  = (state_q == ARB_RUN) && enabled_in && (credits_q != '0);
  assign restart_ok = request_in.restart_request;
  assign wed_ok     = request_in.wed_request   && !restart_pending_in;
  assign write_ok   = request_in.write_request && !restart_pending_in;
  assign read_ok    = request_in.read_request  && !restart_pending_in;

  // Arbitration: restart > wed > round-robin(write, read). A lone write or
  // read requester wins regardless of the pointer.
  always_comb begin
    grant      = '0;
    command_d  = '0;
    rr_write_d = rr_write_q;
    if (can_issue) begin
      if (restart_ok) begin
        grant[G_RESTART] = 1'b1;
        command_d        = cmd_restart_in;
      end else if (wed_ok) begin
        grant[G_WED] = 1'b1;
        command_d    = cmd_wed_in;
      end else if (write_ok && (rr_write_q || !read_ok)) begin
        grant[G_WRITE] = 1'b1;
        command_d      = cmd_write_in;
        rr_write_d     = 1'b0;
      end else if (read_ok) begin
        grant[G_READ] = 1'b1;
        command_d     = cmd_read_in;
        rr_write_d    = 1'b1;
      end
    end
    if (grant != '0) begin
      command_d.valid = 1'b1;
    end
  end

  // One extra bit of headroom so issue and return can be applied together
  // before saturating; credits_q is non-zero whenever a grant happens.
  assign ret_amt    = credit_return_valid_in ? clamp_credits(credit_return_in) : '0;
  assign credit_sum = {1'b0, credits_q} - {{CREDIT_BITS{1'b0}}, |grant} + {1'b0, ret_amt};

  always_comb begin
    state_d   = state_q;
    credits_d = credits_q;
    case (state_q)
      ARB_RESET: begin
        state_d = ARB_WAIT_ROOM;
      end
      ARB_WAIT_ROOM: begin
        // Returns before the room load are meaningless and dropped.
        if (room_valid_in) begin
          credits_d = clamp_credits(room_in);
          state_d   = ARB_RUN;
        end
      end
      ARB_RUN: begin
        credits_d = (credit_sum > {1'b0, MAX_C}) ? MAX_C : credit_sum[CREDIT_BITS-1:0];
      end
      default: begin
        state_d = ARB_RESET;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!rstn) begin
      state_q    <= ARB_RESET;
      credits_q  <= '0;
      rr_write_q <= 1'b1;
      command_q  <= '0;
    end else begin
      state_q    <= state_d;
      credits_q  <= credits_d;
      rr_write_q <= rr_write_d;
      command_q  <= command_d;
    end
  end

  assign grant_out   = grant;
  assign command_out = command_q;
  assign credits_out = credits_q;
  assign state_out   = state_q;

`ifdef CMD_ARB_STATS_EN
  arb_stats_t stats_q;
  logic       stall;

  // A stall is demand that only the empty credit pool is holding back.
  assign stall = (state_q == ARB_RUN) && enabled_in && (credits_q == '0) &&
                 (restart_ok || wed_ok || write_ok || read_ok);

  always_ff @(posedge clock) begin
    if (!rstn) begin
      stats_q <= '0;
    end else begin
      if (grant[G_RESTART]) stats_q.restart_grants <= stats_q.restart_grants + 64'd1;
      if (grant[G_WED])     stats_q.wed_grants     <= stats_q.wed_grants + 64'd1;
      if (grant[G_WRITE])   stats_q.write_grants   <= stats_q.write_grants + 64'd1;
      if (grant[G_READ])    stats_q.read_grants    <= stats_q.read_grants + 64'd1;
      if (stall)            stats_q.stall_cycles   <= stats_q.stall_cycles + 64'd1;
    end
  end

  assign arb_stats_out = stats_q;
`endif

endmodule

// File: tb/tb_command_issue_arbiter.sv
module tb_command_issue_arbiter;
  import command_issue_arbiter_pkg::*;

  logic                           clock = 1'b0;
  logic                           rstn = 1'b0;
  logic                           enabled_in = 1'b1;
  logic                           room_valid_in = 1'b0;
  logic [8:0]                     room_in = '0;
  logic                           credit_return_valid_in = 1'b0;
  logic [8:0]                     credit_return_in = '0;
  logic                           restart_pending_in = 1'b0;
  CommandBufferArbiterInterfaceIn request_in = '0;
  CommandBufferLine               cmd_restart_in = '0;
  CommandBufferLine               cmd_wed_in = '0;
  CommandBufferLine               cmd_write_in = '0;
  CommandBufferLine               cmd_read_in = '0;
  logic [3:0]                     grant_out;
  CommandBufferLine               command_out;
  logic [8:0]                     credits_out;
  logic [1:0]                     state_out;
`ifdef CMD_ARB_STATS_EN
  arb_stats_t                     arb_stats_out;
`endif

  command_issue_arbiter #(.CREDIT_BITS(9), .MAX_CREDITS(64)) dut (
    .clock                  (clock),
    .rstn                   (rstn),
    .enabled_in             (enabled_in),
    .room_valid_in          (room_valid_in),
    .room_in                (room_in),
    .credit_return_valid_in (credit_return_valid_in),
    .credit_return_in       (credit_return_in),
    .restart_pending_in     (restart_pending_in),
    .request_in             (request_in),
    .cmd_restart_in         (cmd_restart_in),
    .cmd_wed_in             (cmd_wed_in),
    .cmd_write_in           (cmd_write_in),
    .cmd_read_in            (cmd_read_in),
    .grant_out              (grant_out),
    .command_out            (command_out),
    .credits_out            (credits_out),
    .state_out              (state_out)
`ifdef CMD_ARB_STATS_EN
    ,
    .arb_stats_out          (arb_stats_out)
`endif
  );

  always #5 clock = ~clock;

  int pass_cnt = 0;
  int fail_cnt = 0;

  // Reference model: phase 0 = reset, 1 = waiting for room, 2 = running.
  int               m_phase = 0;
  int               m_credits = 0;
  int               m_last_rw = 2;   // 1 = write last won, 2 = read last won
  CommandBufferLine m_cmd = '0;

  logic [3:0] gq[$];                 // observed non-zero grants, in order
  logic [3:0] rr_exp[4] = '{4'b0100, 4'b0010, 4'b0100, 4'b0010};
  logic [3:0] fence_exp[7] = '{4'b0001, 4'b0001, 4'b1000, 4'b0100, 4'b0010, 4'b0100, 4'b0010};

  task automatic chk(input logic [127:0] obs, input logic [127:0] exp, input string tag);
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic CommandBufferLine rnd_line();
    logic [127:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom()};
    return CommandBufferLine'(t[$bits(CommandBufferLine)-1:0]);
  endfunction

  function automatic int min64(input int v);
    return (v > 64) ? 64 : v;
  endfunction

  // Which line the specification says should be popped this cycle.
  function automatic logic [3:0] model_grant(output CommandBufferLine sel);
    sel = '0;
    if (m_phase != 2 || !enabled_in || m_credits == 0) return 4'b0000;
    if (request_in.restart_request) begin sel = cmd_restart_in; return 4'b0001; end
    if (restart_pending_in) return 4'b0000;
    if (request_in.wed_request) begin sel = cmd_wed_in; return 4'b1000; end
    if (request_in.write_request && (!request_in.read_request || m_last_rw == 2)) begin
      sel = cmd_write_in; return 4'b0100;
    end
    if (request_in.read_request) begin sel = cmd_read_in; return 4'b0010; end
    return 4'b0000;
  endfunction

  // One clock: compare everything, advance the model across the edge.
  task automatic tick();
    logic [3:0]       eg;
    CommandBufferLine sel;
    #1;
    eg = model_grant(sel);
    chk(128'(grant_out), 128'(eg), "grant");
    chk(128'(command_out), 128'(m_cmd), "command");
    chk(128'(credits_out), 128'(m_credits), "credits");
    chk(128'(state_out), 128'(m_phase), "state");
    if (grant_out != 4'b0000) gq.push_back(grant_out);
    @(posedge clock);
    if (!rstn) begin
      m_phase = 0; m_credits = 0; m_last_rw = 2; m_cmd = '0;
    end else begin
      m_cmd = '0;
      if (m_phase == 0) m_phase = 1;
      else if (m_phase == 1) begin
        if (room_valid_in) begin m_credits = min64(int'(room_in)); m_phase = 2; end
      end else begin
        m_credits = min64(m_credits - (eg != 0 ? 1 : 0) +
                          (credit_return_valid_in ? min64(int'(credit_return_in)) : 0));
        if (eg != 0) begin
          m_cmd = sel; m_cmd.valid = 1'b1;
          if (eg == 4'b0100) m_last_rw = 1;
          if (eg == 4'b0010) m_last_rw = 2;
        end
      end
    end
    @(negedge clock);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    rstn = 1'b0; tick(); rstn = 1'b1; tick();
  endtask

  task automatic load_room(input int v);
    room_valid_in = 1'b1; room_in = 9'(v); tick(); room_valid_in = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    cmd_restart_in = rnd_line(); cmd_wed_in = rnd_line();
    cmd_write_in = rnd_line(); cmd_read_in = rnd_line();
    @(posedge clock); @(negedge clock);
    tick();
    chk(128'(state_out), 128'(0), "reset_state");
    chk(128'(credits_out), 128'(0), "reset_credits");

    // Room load then three reads.
    rstn = 1'b1; tick();
    load_room(64);
    chk(128'(credits_out), 128'(64), "room_load");
    gq.delete();
    request_in = 4'b0010; ticks(3);
    request_in = 4'b0000;
    chk(128'(command_out.valid), 128'(1), "read_cmd_valid");
    tick();
    chk(128'(gq.size()), 128'(3), "read_grant_count");
    chk(128'(credits_out), 128'(61), "read_credits");

    // Round-robin until credits run out.
    do_reset(); load_room(8);
    gq.delete();
    request_in = 4'b0110; ticks(10);
    chk(128'(gq.size()), 128'(8), "rr_count");
    for (int i = 0; i < 8; i++) chk(128'(gq[i]), 128'(rr_exp[i % 4]), "rr_order");
    chk(128'(credits_out), 128'(0), "rr_credits_empty");
    #1 chk(128'(grant_out), 128'(0), "rr_no_grant");

    // Return of 2 at zero credits: exactly two more grants.
    @(negedge clock);
    gq.delete();
    credit_return_valid_in = 1'b1; credit_return_in = 9'd2; tick();
    credit_return_valid_in = 1'b0; ticks(4);
    chk(128'(gq.size()), 128'(2), "return2_grants");
    credit_return_valid_in = 1'b1; credit_return_in = 9'd1; tick();
    tick();                                   // grant and return of 1 together
    credit_return_valid_in = 1'b0; request_in = 4'b0000; tick();
    chk(128'(credits_out), 128'(1), "grant_plus_return");

    // Fence: only restart while pending, then wed, then alternation.
    do_reset(); load_room(64);
    gq.delete();
    request_in = 4'b1111; restart_pending_in = 1'b1; ticks(2);
    restart_pending_in = 1'b0; request_in = 4'b1110; tick();
    request_in = 4'b0110; ticks(4);
    chk(128'(gq.size()), 128'(7), "fence_count");
    for (int i = 0; i < 7; i++) chk(128'(gq[i]), 128'(fence_exp[i]), "fence_order");
    // Pending rises while a write is in flight: that write still issues.
    request_in = 4'b0100; tick();
    gq.delete();
    restart_pending_in = 1'b1; tick();
    chk(128'(command_out.valid), 128'(0), "fenced_pipeline_drained");
    chk(128'(gq.size()), 128'(0), "fenced_no_grant");
    restart_pending_in = 1'b0; request_in = 4'b0000; tick();

    // Saturation and disable.
    do_reset(); load_room(100);
    chk(128'(credits_out), 128'(64), "room_saturate");
    request_in = 4'b0010; ticks(2); request_in = 4'b0000; tick();
    chk(128'(credits_out), 128'(62), "credits_62");
    credit_return_valid_in = 1'b1; credit_return_in = 9'd5; tick();
    credit_return_valid_in = 1'b0;
    chk(128'(credits_out), 128'(64), "return_saturate");
    gq.delete();
    enabled_in = 1'b0; request_in = 4'b1111; ticks(3);
    chk(128'(gq.size()), 128'(0), "disabled_no_grant");
    chk(128'(credits_out), 128'(64), "disabled_credits");
    enabled_in = 1'b1; request_in = 4'b0000;

    // Reset in the cycle after a grant.
    request_in = 4'b0010; tick();
    request_in = 4'b0000; rstn = 1'b0; tick();
    chk(128'(command_out.valid), 128'(0), "midreset_cmd");
    chk(128'(credits_out), 128'(0), "midreset_credits");
    chk(128'(state_out), 128'(0), "midreset_state");
    rstn = 1'b1; gq.delete();
    request_in = 4'b0110; ticks(5);
    chk(128'(gq.size()), 128'(0), "midreset_no_room_no_grant");

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rstn                   = ($urandom_range(0, 99) != 0);
      enabled_in             = ($urandom_range(0, 15) != 0);
      room_valid_in          = ($urandom_range(0, 7) == 0);
      room_in                = 9'($urandom_range(0, 130));
      credit_return_valid_in = ($urandom_range(0, 3) == 0);
      credit_return_in       = ($urandom_range(0, 9) == 0) ? 9'($urandom_range(0, 511))
                                                           : 9'($urandom_range(0, 4));
      restart_pending_in     = ($urandom_range(0, 5) == 0);
      request_in             = 4'($urandom_range(0, 15));
      cmd_restart_in = rnd_line(); cmd_wed_in = rnd_line();
      cmd_write_in = rnd_line(); cmd_read_in = rnd_line();
      tick();
    end

    $display("%0d/%0d checks passed", pass_cnt, pass_cnt + fail_cnt);
    $finish;
  end

endmodule

// File: doc/command_issue_arbiter.md
Name: command_issue_arbiter

Overview:
- Sits between the four AFU command buffers (restart, WED, write, read) and the PSL command interface.
- Each cycle it selects at most one pending command line, under PSL command-credit flow control, and registers it toward the PSL command port.
- Restart has fixed top priority, then WED; write and read share the remaining slots round-robin.
- A restart_pending input fences normal traffic while the restart/flush sequence runs.

Parameters:
- CREDIT_BITS, 9: width of the credit counter; matches response_credits (0:8).
- MAX_CREDITS, 64: clamp for the loaded room value and for returns.

Ports:
- clock  in  1  core clock.
- rstn  in  1  synchronous active-low reset.
- enabled_in  in  1  job enabled; no grants while low.
- room_valid_in  in  1  one-cycle pulse: initial PSL command room is valid.
- room_in  in  CREDIT_BITS  initial room value (ha_croom).
- credit_return_valid_in  in  1  response observed, credits returned.
- credit_return_in  in  CREDIT_BITS  number of credits returned with that response.
- restart_pending_in  in  1  restart/flush in progress; fences wed/write/read.
- request_in  in  4  CommandBufferArbiterInterfaceIn {wed, write, read, restart}; level, buffer non-empty.
- cmd_restart_in, cmd_wed_in, cmd_write_in, cmd_read_in  in  CommandBufferLine each  head-of-FIFO lines (first-word-fall-through).
- grant_out  out  4  one-hot pop pulse, same bit order as request_in.
- command_out  out  CommandBufferLine  registered issued command; .valid qualifies it.
- credits_out  out  CREDIT_BITS  current available credits.
- state_out  out  2  FSM state for debug.

Behaviour:
- Reset (rstn low at clock edge):
  - grant_out=0, command_out=0 (valid=0), credits_out=0, state=ARB_RESET, round-robin pointer=write.
- FSM states:
  - ARB_RESET: always moves to ARB_WAIT_ROOM.
  - ARB_WAIT_ROOM:
    - On room_valid_in, credits <= min(room_in, MAX_CREDITS) and go to ARB_RUN.
    - Returns arriving in this state are ignored.
  - ARB_RUN: arbitrates every cycle. Only reset leaves ARB_RUN.
- Eligibility in ARB_RUN:
  - Grants require enabled_in=1 and credits>0.
  - Restart is eligible if request_in.restart_request.
  - wed/write/read are eligible only if requested and restart_pending_in=0.
- Priority:
  - restart > wed > {write, read}.
  - write/read use round-robin: the pointer toggles to the other requester after each write or read grant.
  - A lone requester wins regardless of the pointer.
- grant_out is combinational from the registered state and current inputs, asserted in cycle N.
  - The buffer pops on that edge.
  - The selected line is registered into command_out with valid=1 at edge N+1, i.e. one-cycle latency.
  - command_out.valid is a single-cycle pulse per grant.
  - Back-to-back grants are allowed every cycle.
- Credit arithmetic per cycle: credits_next = credits - grant_any + (credit_return_valid_in ? credit_return_in : 0).
  - The result saturates at MAX_CREDITS.
  - A simultaneous issue and return are both applied.
  - An issue with credits==0 is impossible by construction.
  - If credits==1 and a grant occurs, no further grant happens until a return arrives.
- restart_pending_in rising while a write grant is in flight:
  - The command already registered still issues.
  - No new non-restart grants follow.
- enabled_in dropping:
  - Stops new grants from the next evaluation.
  - A registered command_out still completes; credits are retained.
- Reset mid-operation discards any registered command and all credits, and requires a new room_valid_in.

Optional Feature:
- CMD_ARB_STATS_EN defined:
  - Adds output arb_stats_out containing four 64-bit counters (restart, wed, write, read grants).
  - Adds a 64-bit stall counter: cycles with any eligible request and credits==0.
  - All counters clear on reset and wrap modulo 2^64.
- Undefined: the port and counters are absent; behaviour is otherwise identical.

Test Plan:
- Room load: reset, room_valid_in with room_in=64 -> credits_out=64. Then 3 single read requests -> 3 read grants, command_out.valid one cycle after each grant, credits_out=61.
- Round-robin: write and read both held high, room=8 -> grants alternate W,R,W,R...; after 8 grants credits_out=0 and grant_out=0.
- Credit return: at credits=0, credit_return_in=2 pulse -> exactly 2 further grants. With a same-cycle grant plus return of 1 at credits=1 -> credits_out=1.
- Priority/fence: all four requests high with restart_pending_in=1 -> only restart granted. Drop restart_pending_in -> wed next, then write/read alternation.
- Saturation and disable: room_in=100 -> credits_out=64. A return of 5 at 62 -> 64. enabled_in=0 with requests high -> no grants, credits unchanged.
- Reset mid-flight: assert rstn=0 in the cycle after a grant -> command_out.valid=0, credits_out=0, state ARB_RESET, no grant until a new room_valid_in.
